grid_collision_scanner: RTL and testbench
=========================================

Name: grid_collision_scanner

Overview:
- Frame-synchronous collision engine for the playfield: checks every tank against the brick grid, and every active missile against the screen bounds and the brick grid.
- Parametrised in tank count, missile count, grid size and sprite sizes. Scans one object per cycle, so combinational depth does not grow with object count.
- For each missile that hits a brick, issues a valid/ready destruction request to the brick-matrix owner.
- Sits between the object position registers and the brick-matrix/game-logic blocks.

Parameters:
NUM_TANKS, 2, number of tanks scanned
NUM_MISSILES, 4, number of missiles scanned
GRID_ROWS, 10, brick grid rows
GRID_COLS, 10, brick grid columns
BRICK_SIZE_LOG2, 5, brick width/height = 2**BRICK_SIZE_LOG2 pixels (32)
TANK_SIZE, 32, tank width/height in pixels (must be <= brick size)
MISSILE_SIZE, 10, missile width/height in pixels (must be <= brick size)
SCREEN_LEFT, 64; SCREEN_RIGHT, 576; SCREEN_TOP, 32; SCREEN_BOTTOM, 416: missile legal area in pixels

Ports:
clk  in  1  system clock
resetN  in  1  synchronous, active-high reset (asserted = 1)
startOfFrame  in  1  one-cycle scan trigger
tankX, tankY  in  NUM_TANKS x 11  tank top-left pixel
missileX, missileY  in  NUM_MISSILES x 11  missile top-left pixel
missileActive  in  NUM_MISSILES  missile in flight
brickMatrix  in  GRID_ROWS x GRID_COLS  1 = brick present, indexed [row][col]
matrixTopLeftX, matrixTopLeftY  in  11  grid origin in pixels
tankCollision  out  NUM_TANKS  tank overlaps a brick
missileCollision  out  NUM_MISSILES  missile hit a brick or left the screen
brickHitValid  out  1  destruction request valid
brickHitRow  out  $clog2(GRID_ROWS)  row of the brick to clear
brickHitCol  out  $clog2(GRID_COLS)  column of the brick to clear
brickHitReady  in  1  destruction request accepted
busy  out  1  scan in progress
scanDone  out  1  one-cycle pulse when the results update

Behaviour:
- Reset (sampled on clk): state IDLE. All outputs 0, including tankCollision, missileCollision, brickHitValid, brickHitRow/Col, busy and scanDone. Shadow result registers and the requested-mask are cleared.
- A reset mid-scan aborts the scan: no scanDone, and brickHitValid drops at that edge.
- FSM: IDLE -> CAPTURE -> TANK -> MISSILE <-> HIT_REQ -> DONE -> IDLE.
- IDLE: startOfFrame=1 -> CAPTURE. startOfFrame is ignored in every other state.
- CAPTURE (1 cycle): snapshot all positions, missileActive, brickMatrix and the grid origin. Clear the requested-mask. busy=1 from this cycle until DONE inclusive.
- Offset arithmetic: offset = position - origin, computed in signed 12 bits. Cell = offset >>> BRICK_SIZE_LOG2; remainder = low BRICK_SIZE_LOG2 bits of offset.
- Cell lookup: a cell outside 0..GRID_ROWS-1 / 0..GRID_COLS-1, including negative offsets, counts as solid.
- TANK (1 cycle per tank, index 0 upward): collision when any of these cells is solid:
  - [r][c]
  - [r][c+1] if remRight>0
  - [r+1][c] if remBottom>0
  - [r+1][c+1] if both remainders >0
  - Result goes to a shadow register.
- MISSILE (1 cycle per missile):
  - Inactive missile: result 0.
  - Bounds hit: x<SCREEN_LEFT, x+MISSILE_SIZE>SCREEN_RIGHT, y<SCREEN_TOP, or y+MISSILE_SIZE>SCREEN_BOTTOM. Evaluated in 12-bit unsigned arithmetic.
  - Brick hit: a missile's corner cells that is in-grid and holds a brick, using the same 4-cell rule with MISSILE_SIZE; the hit cell is the first such cell in order TL, TR, BL, BR.
  - Collision = bounds hit OR brick hit. An out-of-grid cell counts toward collision but never produces a request.
  - If a brick hit exists and that cell is not already in the requested-mask -> HIT_REQ.
  - Otherwise advance to the next missile.
- HIT_REQ:
  - brickHitValid=1 with row/col stable until brickHitValid && brickHitReady at a clock edge.
  - On that transfer: set the mask bit, drop valid, return to MISSILE at the next index.
  - Minimum one cycle per request; each cycle of ready=0 adds one cycle.
  - Missile collision is judged on the snapshot. A second missile hitting an already-requested brick still flags collision but issues no request.
- DONE (1 cycle): copy shadow results to tankCollision/missileCollision simultaneously; scanDone=1; -> IDLE. Outputs hold until the next DONE.
- Latency with no requests: scanDone is high NUM_TANKS+NUM_MISSILES+2 cycles after the cycle startOfFrame was sampled, plus the HIT_REQ cycles.
- A startOfFrame in the same cycle as DONE is ignored.

Test Plan:
- Defaults, origin (64,32), brickMatrix[1][1]=1, tank0 at (96,64) -> tankCollision[0]=1. Same tank with only [1][2]=1 -> 0. Tank0 at (100,64) with only [1][2]=1 -> 1.
- Tank0 at (40,64) (negative X offset) with empty matrix -> tankCollision[0]=1. Missile0 at (60,100), active -> missileCollision[0]=1, brickHitValid never asserted.
- Missile0 at (128,96), active, [2][2]=1, brickHitReady tied high -> brickHitValid for 1 cycle with row=2, col=2. missileCollision[0]=1. scanDone 9 cycles after startOfFrame.
- As above, ready held low 3 cycles -> row/col stable throughout. scanDone delayed by exactly 3 cycles. Missile1 at the same position -> missileCollision[1]=1 and only one request.
- startOfFrame pulsed while busy -> ignored, exactly one scanDone. missileActive=0 at a colliding position -> missileCollision bit 0.
- resetN=1 during HIT_REQ -> brickHitValid=0 at the next edge, all outputs 0, no scanDone. A new startOfFrame then completes normally.

Source files
------------

// File: rtl/grid_collision_scanner.sv
// Frame-synchronous collision scanner: one tank or missile per cycle against the brick grid and
// screen bounds, with a valid/ready destruction request for every newly hit brick.
module grid_collision_scanner #(
  parameter int NUM_TANKS       = 2,
  parameter int NUM_MISSILES    = 4,
  parameter int GRID_ROWS       = 10,
  parameter int GRID_COLS       = 10,
  parameter int BRICK_SIZE_LOG2 = 5,
  parameter int TANK_SIZE       = 32,
  parameter int MISSILE_SIZE    = 10,
  parameter int SCREEN_LEFT     = 64,
  parameter int SCREEN_RIGHT    = 576,
  parameter int SCREEN_TOP      = 32,
  parameter int SCREEN_BOTTOM   = 416,
  localparam int ROW_W = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1,
  localparam int COL_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1
) (
  input  logic                                   clk,
  input  logic                                   resetN,
  input  logic                                   startOfFrame,
  input  logic [NUM_TANKS-1:0][10:0]             tankX,
  input  logic [NUM_TANKS-1:0][10:0]             tankY,
  input  logic [NUM_MISSILES-1:0][10:0]          missileX,
  input  logic [NUM_MISSILES-1:0][10:0]          missileY,
  input  logic [NUM_MISSILES-1:0]                missileActive,
  input  logic [GRID_ROWS-1:0][GRID_COLS-1:0]    brickMatrix,
  input  logic [10:0]                            matrixTopLeftX,
  input  logic [10:0]                            matrixTopLeftY,
  output logic [NUM_TANKS-1:0]                   tankCollision,
  output logic [NUM_MISSILES-1:0]                missileCollision,
  output logic                                   brickHitValid,
  output logic [ROW_W-1:0]                       brickHitRow,
  output logic [COL_W-1:0]                       brickHitCol,
  input  logic                                   brickHitReady,
  output logic                                   busy,
  output logic                                   scanDone
);

  localparam int TSEL_W = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1;
  localparam int MSEL_W = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1;
  localparam int IDX_W  = (TSEL_W > MSEL_W) ? TSEL_W : MSEL_W;
  localparam int CELLS  = GRID_ROWS * GRID_COLS;
  localparam int MASK_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_TANK, S_MISSILE, S_HIT_REQ, S_DONE
  } state_t;

  typedef struct packed {
    logic             solid;
    logic             brick;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } probe_t;

  state_t                                state_r, state_nxt;
  logic [IDX_W-1:0]                      idx_r, idx_nxt;
  logic [NUM_TANKS-1:0][10:0]            tank_x_r, tank_y_r;
  logic [NUM_MISSILES-1:0][10:0]         mis_x_r, mis_y_r;
  logic [NUM_MISSILES-1:0]               mis_active_r;
  logic [GRID_ROWS-1:0][GRID_COLS-1:0]   matrix_r;
  logic [10:0]                           org_x_r, org_y_r;
  logic [CELLS-1:0]                      mask_r;
  logic [MASK_W-1:0]                     hit_lin_r;
  logic [NUM_TANKS-1:0]                  tank_shadow_r;
  logic [NUM_MISSILES-1:0]               mis_shadow_r, mis_shadow_nxt;
  logic [TSEL_W-1:0]                     tank_sel_s;
  logic [MSEL_W-1:0]                     mis_sel_s;
  probe_t                                tank_probe_s, mis_probe_s;
  logic [11:0]                           mis_x_s, mis_y_s;
  logic                                  bounds_s, mis_result_s, need_req_s;
  logic                                  tank_last_s, mis_last_s;
  logic [MASK_W-1:0]                     mask_idx_s;

  // Checks the up-to-four grid cells covered by a square sprite; out-of-grid cells are solid,
  // and the first in-grid brick in TL, TR, BL, BR order is reported as the hit cell.
  function automatic probe_t probe(input logic [10:0] px, input logic [10:0] py,
                                   input logic [11:0] size,
                                   input logic [10:0] ox, input logic [10:0] oy,
                                   input logic [GRID_ROWS-1:0][GRID_COLS-1:0] mat);
    logic signed [11:0] off_x, off_y, cl, cr, rt, rb, r, c;
    logic               in_grid, hit;
    probe_t             p;
    p     = '0;
    off_x = $signed({1'b0, px}) - $signed({1'b0, ox});
    off_y = $signed({1'b0, py}) - $signed({1'b0, oy});
    cl    = off_x >>> BRICK_SIZE_LOG2;
    cr    = (off_x + $signed(size - 12'd1)) >>> BRICK_SIZE_LOG2;
    rt    = off_y >>> BRICK_SIZE_LOG2;
    rb    = (off_y + $signed(size - 12'd1)) >>> BRICK_SIZE_LOG2;
    for (int k = 0; k < 4; k++) begin
      r       = k[1] ? rb : rt;
      c       = k[0] ? cr : cl;
      in_grid = !r[11] && !c[11] && ($unsigned(r) < 12'(GRID_ROWS)) &&
                ($unsigned(c) < 12'(GRID_COLS));
      hit     = in_grid && mat[r[ROW_W-1:0]][c[COL_W-1:0]];
      p.solid = p.solid | !in_grid | hit;
      p.row   = (hit && !p.brick) ? r[ROW_W-1:0] : p.row;
      p.col   = (hit && !p.brick) ? c[COL_W-1:0] : p.col;
      p.brick = p.brick | hit;
    end
    return p;
  endfunction

  assign tank_sel_s  = idx_r[TSEL_W-1:0];
  assign mis_sel_s   = idx_r[MSEL_W-1:0];
  assign tank_last_s = (idx_r == IDX_W'(NUM_TANKS - 1));
  assign mis_last_s  = (idx_r == IDX_W'(NUM_MISSILES - 1));

  // Per-object evaluation of the currently indexed tank and missile.
  always_comb begin
    tank_probe_s = probe(tank_x_r[tank_sel_s], tank_y_r[tank_sel_s], 12'(TANK_SIZE),
                         org_x_r, org_y_r, matrix_r);
    mis_probe_s  = probe(mis_x_r[mis_sel_s], mis_y_r[mis_sel_s], 12'(MISSILE_SIZE),
                         org_x_r, org_y_r, matrix_r);
    mis_x_s      = {1'b0, mis_x_r[mis_sel_s]};
    mis_y_s      = {1'b0, mis_y_r[mis_sel_s]};
    bounds_s     = (mis_x_s < 12'(SCREEN_LEFT)) ||
                   ((mis_x_s + 12'(MISSILE_SIZE)) > 12'(SCREEN_RIGHT)) ||
                   (mis_y_s < 12'(SCREEN_TOP)) ||
                   ((mis_y_s + 12'(MISSILE_SIZE)) > 12'(SCREEN_BOTTOM));
    mis_result_s = mis_active_r[mis_sel_s] && (bounds_s || mis_probe_s.solid);
    mask_idx_s   = MASK_W'(mis_probe_s.row) * MASK_W'(GRID_COLS) + MASK_W'(mis_probe_s.col);
    need_req_s   = mis_active_r[mis_sel_s] && mis_probe_s.brick && !mask_r[mask_idx_s];
    mis_shadow_nxt = mis_shadow_r;
    if (state_r == S_MISSILE) begin
      mis_shadow_nxt[mis_sel_s] = mis_result_s;
    end else begin
      mis_shadow_nxt = mis_shadow_r;
    end
  end

  // Next-state and object index sequencing.
  always_comb begin
    state_nxt = state_r;
    idx_nxt   = idx_r;
    case (state_r)
      S_IDLE: begin
        if (startOfFrame) state_nxt = S_CAPTURE;
        else              state_nxt = S_IDLE;
      end
      S_CAPTURE: begin
        state_nxt = S_TANK;
        idx_nxt   = '0;
      end
      S_TANK: begin
        if (tank_last_s) begin
          state_nxt = S_MISSILE;
          idx_nxt   = '0;
        end else begin
          idx_nxt   = idx_r + IDX_W'(1);
        end
      end
      S_MISSILE: begin
        if (need_req_s)      state_nxt = S_HIT_REQ;
        else if (mis_last_s) state_nxt = S_DONE;
        else                 idx_nxt   = idx_r + IDX_W'(1);
      end
      S_HIT_REQ: begin
        if (brickHitReady && mis_last_s) begin
          state_nxt = S_DONE;
        end else if (brickHitReady) begin
          state_nxt = S_MISSILE;
          idx_nxt   = idx_r + IDX_W'(1);
        end else begin
          state_nxt = S_HIT_REQ;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state, snapshot, shadow results and requested-brick mask.
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_r       <= S_IDLE;
      idx_r         <= '0;
      tank_x_r      <= '0;
      tank_y_r      <= '0;
      mis_x_r       <= '0;
      mis_y_r       <= '0;
      mis_active_r  <= '0;
      matrix_r      <= '0;
      org_x_r       <= 11'd0;
      org_y_r       <= 11'd0;
      mask_r        <= '0;
      hit_lin_r     <= '0;
      tank_shadow_r <= '0;
      mis_shadow_r  <= '0;
    end else begin
      state_r      <= state_nxt;
      idx_r        <= idx_nxt;
      mis_shadow_r <= mis_shadow_nxt;
      if (state_r == S_CAPTURE) begin
        tank_x_r     <= tankX;
        tank_y_r     <= tankY;
        mis_x_r      <= missileX;
        mis_y_r      <= missileY;
        mis_active_r <= missileActive;
        matrix_r     <= brickMatrix;
        org_x_r      <= matrixTopLeftX;
        org_y_r      <= matrixTopLeftY;
        mask_r       <= '0;
      end else if (state_r == S_HIT_REQ && brickHitReady) begin
        mask_r[hit_lin_r] <= 1'b1;
      end else begin
        mask_r <= mask_r;
      end
      if (state_r == S_TANK) begin
        tank_shadow_r[tank_sel_s] <= tank_probe_s.solid;
      end else begin
        tank_shadow_r <= tank_shadow_r;
      end
      if (state_r == S_MISSILE && need_req_s) begin
        hit_lin_r <= mask_idx_s;
      end else begin
        hit_lin_r <= hit_lin_r;
      end
    end
  end

  // Registered outputs, decoded from the state being entered so they align with it.
  always_ff @(posedge clk) begin
    if (resetN) begin
      tankCollision    <= '0;
      missileCollision <= '0;
      brickHitValid    <= 1'b0;
      brickHitRow      <= '0;
      brickHitCol      <= '0;
      busy             <= 1'b0;
      scanDone         <= 1'b0;
    end else begin
      busy          <= (state_nxt != S_IDLE);
      scanDone      <= (state_nxt == S_DONE);
      brickHitValid <= (state_nxt == S_HIT_REQ);
      if (state_r == S_MISSILE && need_req_s) begin
        brickHitRow <= mis_probe_s.row;
        brickHitCol <= mis_probe_s.col;
      end else begin
        brickHitRow <= brickHitRow;
        brickHitCol <= brickHitCol;
      end
      if (state_nxt == S_DONE) begin
        tankCollision    <= tank_shadow_r;
        missileCollision <= mis_shadow_nxt;
      end else begin
        tankCollision    <= tankCollision;
        missileCollision <= missileCollision;
      end
    end
  end

endmodule

// File: tb/tb_grid_collision_scanner.sv
// Self-checking bench for grid_collision_scanner: table-driven frames with a scoreboard queue,
// plus hand sequences for back-pressure, ignored triggers and reset during a request.
module tb_grid_collision_scanner;
  localparam int NT = 2;
  localparam int NM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  resetN, startOfFrame, brickHitReady;
  logic [NT-1:0][10:0]   tankX, tankY;
  logic [NM-1:0][10:0]   missileX, missileY;
  logic [NM-1:0]         missileActive;
  logic [9:0][9:0]       brickMatrix;
  logic [10:0]           matrixTopLeftX, matrixTopLeftY;
  logic [NT-1:0]         tankCollision;
  logic [NM-1:0]         missileCollision;
  logic                  brickHitValid, busy, scanDone;
  logic [3:0]            brickHitRow, brickHitCol;

  grid_collision_scanner dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .tankX(tankX), .tankY(tankY), .missileX(missileX), .missileY(missileY),
    .missileActive(missileActive), .brickMatrix(brickMatrix),
    .matrixTopLeftX(matrixTopLeftX), .matrixTopLeftY(matrixTopLeftY),
    .tankCollision(tankCollision), .missileCollision(missileCollision),
    .brickHitValid(brickHitValid), .brickHitRow(brickHitRow), .brickHitCol(brickHitCol),
    .brickHitReady(brickHitReady), .busy(busy), .scanDone(scanDone)
  );

  typedef struct {
    logic [NT-1:0] tank;
    logic [NM-1:0] mis;
    int reqs; int row; int col; int lat;
  } exp_t;

  typedef struct {
    int tx, ty, mx, my, mact, r1, c1, r2, c2, t0, m0, reqs, row, col, lat;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[17];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic set_defaults();
    matrixTopLeftX = 11'd64;
    matrixTopLeftY = 11'd32;
    tankX[0] = 11'd224; tankY[0] = 11'd256;
    tankX[1] = 11'd160; tankY[1] = 11'd160;
    for (int i = 0; i < NM; i++) begin
      missileX[i] = 11'd300; missileY[i] = 11'd200;
    end
    missileActive = '0;
    brickMatrix   = '0;
  endtask

  // Pulses startOfFrame, serves requests (holding ready low 'hold' cycles), checks against the
  // scoreboard entry when scanDone appears.
  task automatic run_frame(input string tag, input int hold, input exp_t e);
    int lat, reqs, held, bad;
    bit done;
    exp_t x;
    sb_q.push_back(e);
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    lat = 1; reqs = 0; held = hold; bad = 0; done = 1'b0;
    while (!done && lat < 60) begin
      if (scanDone) begin
        done = 1'b1;
      end else begin
        if (brickHitValid) begin
          if (int'(brickHitRow) != sb_q[0].row || int'(brickHitCol) != sb_q[0].col) bad++;
          if (held > 0) begin brickHitReady = 1'b0; held--; end
          else begin brickHitReady = 1'b1; reqs++; end
        end else begin
          brickHitReady = 1'b1;
        end
        @(negedge clk); lat++;
      end
    end
    chk({tag, " scanDone_seen"}, done, 1);
    x = sb_q.pop_front();
    if (done) begin
      chk({tag, " tankCollision"}, tankCollision, x.tank);
      chk({tag, " missileCollision"}, missileCollision, x.mis);
      chk({tag, " requests"}, reqs, x.reqs);
      chk({tag, " latency"}, lat, x.lat);
      if (x.reqs > 0) chk({tag, " row_col_bad_cycles"}, bad, 0);
      @(negedge clk);
      chk({tag, " scanDone_pulse"}, scanDone, 0);
    end
  endtask

  initial begin
    exp_t e;
    int dones, seen;
    // tx ty mx my mact r1 c1 r2 c2 | t0 m0 reqs row col lat
    vecs[0]  = '{ 96,  64, 300, 200, 0,  1,  1, -1, -1, 1, 0, 0, 0, 0, 8};
    vecs[1]  = '{ 96,  64, 300, 200, 0,  1,  2, -1, -1, 0, 0, 0, 0, 0, 8};
    vecs[2]  = '{100,  64, 300, 200, 0,  1,  2, -1, -1, 1, 0, 0, 0, 0, 8};
    vecs[3]  = '{ 40,  64, 300, 200, 0, -1, -1, -1, -1, 1, 0, 0, 0, 0, 8};
    vecs[4]  = '{352, 320, 300, 200, 0, -1, -1, -1, -1, 0, 0, 0, 0, 0, 8};
    vecs[5]  = '{353, 320, 300, 200, 0, -1, -1, -1, -1, 1, 0, 0, 0, 0, 8};
    vecs[6]  = '{224, 256,  60, 100, 1, -1, -1, -1, -1, 0, 1, 0, 0, 0, 8};
    vecs[7]  = '{224, 256, 128,  96, 1,  2,  2, -1, -1, 0, 1, 1, 2, 2, 9};
    vecs[8]  = '{224, 256, 128,  96, 0,  2,  2, -1, -1, 0, 0, 0, 0, 0, 8};
    vecs[9]  = '{224, 256, 153,  96, 1,  2,  3, -1, -1, 0, 1, 1, 2, 3, 9};
    vecs[10] = '{224, 256, 128, 119, 1,  3,  2, -1, -1, 0, 1, 1, 3, 2, 9};
    vecs[11] = '{224, 256,  64,  32, 1, -1, -1, -1, -1, 0, 0, 0, 0, 0, 8};
    vecs[12] = '{224, 256, 374,  96, 1, -1, -1, -1, -1, 0, 0, 0, 0, 0, 8};
    vecs[13] = '{224, 256, 375,  96, 1, -1, -1, -1, -1, 0, 1, 0, 0, 0, 8};
    vecs[14] = '{224, 256, 300, 200, 1,  5,  7, -1, -1, 0, 1, 1, 5, 7, 9};
    vecs[15] = '{224, 256, 153, 119, 1,  3,  3, -1, -1, 0, 1, 1, 3, 3, 9};
    vecs[16] = '{224, 256, 153, 119, 1,  3,  2,  2,  3, 0, 1, 1, 2, 3, 9};

    resetN = 1'b1; startOfFrame = 1'b0; brickHitReady = 1'b1;
    set_defaults();
    repeat (3) @(negedge clk);
    chk("reset tankCollision", tankCollision, 0);
    chk("reset missileCollision", missileCollision, 0);
    chk("reset valid_busy_done", {brickHitValid, busy, scanDone}, 0);
    chk("reset row_col", {brickHitRow, brickHitCol}, 0);
    resetN = 1'b0;

    for (int i = 0; i < 17; i++) begin
      set_defaults();
      tankX[0] = 11'(vecs[i].tx); tankY[0] = 11'(vecs[i].ty);
      missileX[0] = 11'(vecs[i].mx); missileY[0] = 11'(vecs[i].my);
      missileActive[0] = vecs[i].mact[0];
      if (vecs[i].r1 >= 0) brickMatrix[vecs[i].r1][vecs[i].c1] = 1'b1;
      if (vecs[i].r2 >= 0) brickMatrix[vecs[i].r2][vecs[i].c2] = 1'b1;
      e.tank = {1'b0, vecs[i].t0[0]};
      e.mis  = {3'b000, vecs[i].m0[0]};
      e.reqs = vecs[i].reqs; e.row = vecs[i].row; e.col = vecs[i].col; e.lat = vecs[i].lat;
      run_frame($sformatf("vec%0d", i), 0, e);
    end

    // Triggers while busy and during DONE must be ignored.
    set_defaults();
    e = '{tank: 2'b00, mis: 4'b0000, reqs: 0, row: 0, col: 0, lat: 8};
    sb_q.push_back(e);
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    dones = 0;
    for (int i = 1; i < 40; i++) begin
      if (i == 1) chk("busy_in_capture", busy, 1);
      startOfFrame = (i == 3) || scanDone;
      if (scanDone) begin
        dones++;
        chk("retrigger latency", i, 8);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("retrigger missileCollision", missileCollision, e.mis);
        end
      end
      @(negedge clk);
    end
    startOfFrame = 1'b0;
    chk("retrigger scanDone_count", dones, 1);
    chk("retrigger busy_idle", busy, 0);

    // Two missiles on one brick with back-pressure: a single request, both flagged.
    set_defaults();
    tankX[0] = 11'd40; tankY[0] = 11'd64;
    missileX[0] = 11'd128; missileY[0] = 11'd96;
    missileX[1] = 11'd128; missileY[1] = 11'd96;
    missileActive = 4'b0011;
    brickMatrix[2][2] = 1'b1;
    run_frame("shared_brick", 3, '{tank: 2'b01, mis: 4'b0011, reqs: 1, row: 2, col: 2, lat: 12});

    // Reset while a request is pending aborts the scan.
    set_defaults();
    tankX[0] = 11'd40; tankY[0] = 11'd64;
    missileX[0] = 11'd128; missileY[0] = 11'd96;
    missileActive = 4'b0001;
    brickMatrix[2][2] = 1'b1;
    brickHitReady = 1'b0;
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      if (brickHitValid) seen = 1;
      else @(negedge clk);
    end
    chk("abort valid_seen", seen, 1);
    chk("abort outputs_held", missileCollision, 3);
    resetN = 1'b1;
    @(negedge clk);
    chk("abort brickHitValid", brickHitValid, 0);
    chk("abort busy", busy, 0);
    chk("abort collisions", {tankCollision, missileCollision}, 0);
    resetN = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (scanDone) dones++;
      @(negedge clk);
    end
    chk("abort no_scanDone", dones, 0);
    brickHitReady = 1'b1;
    run_frame("after_abort", 0, '{tank: 2'b01, mis: 4'b0001, reqs: 1, row: 2, col: 2, lat: 9});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
